// File: rtl/decoder_pkg.sv
// Shared types and constants for the trace stimulus generator: priority levels,
// generator state encoding and the default sample word width.
package decoder_pkg;

  localparam int unsigned FifoEntryWidthBits = 32;

  typedef logic [1:0] PrioT;

  localparam PrioT IDLE_LEVEL    = 2'd2;
  localparam PrioT BURST_LEVEL   = 2'd1;
  localparam PrioT PREEMPT_LEVEL = 2'd0;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StBurst,
    StDone
  } stim_state_e;

endpackage

// File: rtl/stim_sample_store.sv
// Sample register file: one synchronous write port, one asynchronous read port.
// Deliberately has no reset so software-loaded samples survive a generator reset.
module stim_sample_store #(
  parameter int unsigned NUM_SAMPLES = 4,
  parameter int unsigned DATA_W      = 32,
  localparam int unsigned IdxW       = $clog2(NUM_SAMPLES)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [IdxW-1:0]   wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IdxW-1:0]   rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [NUM_SAMPLES];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/trace_stim_gen.sv
// Periodic / one-shot burst generator feeding stored sample words to a trace encoder
// with a valid/ready handshake and an optional preempt-level word.
module trace_stim_gen
  import decoder_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 4,
  parameter int unsigned PERIOD_W    = 26,
  parameter int unsigned DATA_W      = FifoEntryWidthBits,
  localparam int unsigned IdxW       = $clog2(NUM_SAMPLES)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                one_shot_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                preempt_en_i,
  input  logic [IdxW-1:0]     preempt_idx_i,
  input  logic                load_en_i,
  input  logic [IdxW-1:0]     load_idx_i,
  input  logic [DATA_W-1:0]   load_data_i,
  input  logic                ready_i,
  output logic                csr_enable_o,
  output logic [DATA_W-1:0]   rs1_data_o,
  output PrioT                level_o,
  output logic                busy_o,
  output logic [15:0]         burst_cnt_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SAMPLES - 1);

  stim_state_e         state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                csr_en_q, csr_en_d;
  logic [DATA_W-1:0]   rs1_q, rs1_d;
  PrioT                level_q, level_d;
  logic                busy_q, busy_d;
  logic [15:0]         burst_cnt_q, burst_cnt_d;

  logic [PERIOD_W-1:0] wait_last;
  logic [IdxW-1:0]     rd_idx;
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]   fetch_data;

  assign wait_last = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);

  stim_sample_store #(
    .NUM_SAMPLES(NUM_SAMPLES),
    .DATA_W     (DATA_W)
  ) u_store (
    .clk_i    (clk_i),
    .wr_en_i  (load_en_i),
    .wr_idx_i (load_idx_i),
    .wr_data_i(load_data_i),
    .rd_idx_i (rd_idx),
    .rd_data_o(rd_data)
  );

  // Read the word that will be presented next cycle.
  always_comb begin
    rd_idx = '0;
    if (state_q == StBurst) begin
      rd_idx = (ready_i && idx_q != LastIdx) ? idx_q + IdxW'(1) : idx_q;
    end
  end

  // Same-cycle write to the word about to be presented wins over the stale store value.
  assign fetch_data = (load_en_i && load_idx_i == rd_idx) ? load_data_i : rd_data;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    csr_en_d    = 1'b0;
    rs1_d       = rs1_q;
    level_d     = IDLE_LEVEL;
    burst_cnt_d = burst_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (cnt_q == wait_last) begin
          state_d  = StBurst;
          idx_d    = '0;
          csr_en_d = 1'b1;
          rs1_d    = fetch_data;
          level_d  = (preempt_en_i && preempt_idx_i == '0) ? PREEMPT_LEVEL : BURST_LEVEL;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      StBurst: begin
        if (!ready_i) begin
          csr_en_d = 1'b1;
          rs1_d    = fetch_data;
          level_d  = level_q;
        end else if (idx_q == LastIdx) begin
          burst_cnt_d = burst_cnt_q + 16'd1;
          idx_d       = '0;
          cnt_d       = '0;
          state_d     = one_shot_i ? StDone : (enable_i ? StWait : StIdle);
        end else begin
          idx_d    = idx_q + IdxW'(1);
          csr_en_d = 1'b1;
          rs1_d    = fetch_data;
          level_d  = (preempt_en_i && preempt_idx_i == idx_d) ? PREEMPT_LEVEL : BURST_LEVEL;
        end
      end
      StDone: begin
        if (!enable_i) begin
          state_d = StIdle;
        end
      end
    endcase

    busy_d = (state_d == StWait) || (state_d == StBurst);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      csr_en_q    <= 1'b0;
      rs1_q       <= '0;
      level_q     <= IDLE_LEVEL;
      busy_q      <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      csr_en_q    <= csr_en_d;
      rs1_q       <= rs1_d;
      level_q     <= level_d;
      busy_q      <= busy_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign csr_enable_o = csr_en_q;
  assign rs1_data_o   = rs1_q;
  assign level_o      = level_q;
  assign busy_o       = busy_q;
  assign burst_cnt_o  = burst_cnt_q;

endmodule

// File: tb/tb_trace_stim_gen.sv
// Bench for trace_stim_gen: directed scenarios plus randomized bursts, checked
// against a sample-store model and timing rules for WAIT length and handshake.
module tb_trace_stim_gen;
  import decoder_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          enable_i;
  logic          one_shot_i;
  logic [PW-1:0] period_i;
  logic          preempt_en_i;
  logic [IW-1:0] preempt_idx_i;
  logic          load_en_i;
  logic [IW-1:0] load_idx_i;
  logic [DW-1:0] load_data_i;
  logic          ready_i;
  logic          csr_enable_o;
  logic [DW-1:0] rs1_data_o;
  PrioT          level_o;
  logic          busy_o;
  logic [15:0]   burst_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_bursts = 0;
  logic [DW-1:0] model_mem [N];

  always #5 clk = ~clk;

  trace_stim_gen #(
    .NUM_SAMPLES(N),
    .PERIOD_W   (PW),
    .DATA_W     (DW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .one_shot_i   (one_shot_i),
    .period_i     (period_i),
    .preempt_en_i (preempt_en_i),
    .preempt_idx_i(preempt_idx_i),
    .load_en_i    (load_en_i),
    .load_idx_i   (load_idx_i),
    .load_data_i  (load_data_i),
    .ready_i      (ready_i),
    .csr_enable_o (csr_enable_o),
    .rs1_data_o   (rs1_data_o),
    .level_o      (level_o),
    .busy_o       (busy_o),
    .burst_cnt_o  (burst_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_period(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic load_word(input int idx, input logic [31:0] d);
    load_en_i   = 1'b1;
    load_idx_i  = idx[IW-1:0];
    load_data_i = d;
    model_mem[idx] = d;
    step();
    load_en_i = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input int exp_wait, input string tag);
    int waited;
    waited = 0;
    while (csr_enable_o !== 1'b1 && waited < budget) begin
      step();
      waited++;
    end
    chk({tag, "_valid"}, {31'd0, csr_enable_o}, 32'd1);
    chk({tag, "_gap"}, waited, exp_wait);
  endtask

  // Present-and-consume loop: each presented word must equal the model store entry.
  task automatic do_burst(input int ready_pct, input int load_pct, input int stall_at,
                          input int stall_len, input int drop_at, input string tag,
                          output int cycles);
    int   k;
    int   stalls;
    int   li;
    logic r;
    logic [31:0] ld;
    logic [31:0] exp_lvl;
    k = 0;
    cycles = 0;
    stalls = stall_len;
    while (k < N && cycles < 300) begin
      if (k == stall_at && stalls > 0) begin
        r = 1'b0;
        stalls--;
      end else begin
        r = ($urandom_range(99) < ready_pct);
      end
      if (k == drop_at) enable_i = 1'b0;
      ready_i = r;
      exp_lvl = (preempt_en_i && int'(preempt_idx_i) == k) ? 32'd0 : 32'd1;
      chk({tag, "_data"}, rs1_data_o, model_mem[k]);
      chk({tag, "_csr"}, {31'd0, csr_enable_o}, 32'd1);
      chk({tag, "_level"}, {30'd0, level_o}, exp_lvl);
      chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
      load_en_i = 1'b0;
      if ($urandom_range(99) < load_pct) begin
        li = $urandom_range(N - 1);
        ld = $urandom;
        load_en_i   = 1'b1;
        load_idx_i  = li[IW-1:0];
        load_data_i = ld;
        model_mem[li] = ld;
      end
      step();
      cycles++;
      if (r) k++;
    end
    load_en_i = 1'b0;
    ready_i   = 1'b0;
    exp_bursts++;
    chk({tag, "_words"}, k, N);
    chk({tag, "_end_csr"}, {31'd0, csr_enable_o}, 32'd0);
    chk({tag, "_end_level"}, {30'd0, level_o}, {30'd0, IDLE_LEVEL});
    chk({tag, "_burst_cnt"}, {16'd0, burst_cnt_o}, exp_bursts);
  endtask

  initial begin
    int cyc;
    int p;
    reset_i       = 1'b1;
    enable_i      = 1'b0;
    one_shot_i    = 1'b0;
    period_i      = PW'(8);
    preempt_en_i  = 1'b0;
    preempt_idx_i = '0;
    load_en_i     = 1'b0;
    load_idx_i    = '0;
    load_data_i   = '0;
    ready_i       = 1'b0;
    step();
    step();
    chk("rst_csr", {31'd0, csr_enable_o}, 32'd0);
    chk("rst_data", rs1_data_o, 32'd0);
    chk("rst_level", {30'd0, level_o}, 32'd2);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_cnt", {16'd0, burst_cnt_o}, 32'd0);
    reset_i = 1'b0;

    load_word(0, 32'h13);
    load_word(1, 32'h00);
    load_word(2, 32'h37);
    load_word(3, 32'hDE);

    // Basic burst with preempt on the last word
    period_i      = PW'(8);
    preempt_en_i  = 1'b1;
    preempt_idx_i = 2'd3;
    enable_i      = 1'b1;
    step();
    chk("wait_busy", {31'd0, busy_o}, 32'd1);
    wait_valid(50, 8, "r036_first");
    do_burst(100, 0, -1, 0, -1, "r036", cyc);
    chk("r036_cycles", cyc, 4);

    // Three-cycle stall on word 1
    preempt_en_i = 1'b0;
    wait_valid(50, 8, "r037_gap");
    period_i = '0;
    do_burst(100, 0, 1, 3, -1, "r037", cyc);
    chk("r037_cycles", cyc, 7);

    // period 0 behaves as 1
    wait_valid(10, 1, "r039a");
    do_burst(100, 0, -1, 0, -1, "r039", cyc);
    wait_valid(10, 1, "r039b");

    // Enable dropped mid-burst: burst completes then idles
    do_burst(100, 0, -1, 0, 1, "r041", cyc);
    chk("r041_busy", {31'd0, busy_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r041_idle_csr", {31'd0, csr_enable_o}, 32'd0);
    end

    // Enable dropped during WAIT returns to IDLE next cycle
    period_i = PW'(6);
    enable_i = 1'b1;
    step();
    chk("wdrop_busy_on", {31'd0, busy_o}, 32'd1);
    enable_i = 1'b0;
    step();
    chk("wdrop_busy_off", {31'd0, busy_o}, 32'd0);
    for (int i = 0; i < 8; i++) step();
    chk("wdrop_no_burst", {31'd0, csr_enable_o}, 32'd0);

    // One-shot: single burst then DONE until enable toggles
    one_shot_i = 1'b1;
    period_i   = PW'(5);
    enable_i   = 1'b1;
    wait_valid(50, 6, "r038");
    do_burst(70, 20, -1, 0, -1, "r038", cyc);
    chk("r038_busy", {31'd0, busy_o}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("r038_done_csr", {31'd0, csr_enable_o}, 32'd0);
      chk("r038_done_busy", {31'd0, busy_o}, 32'd0);
    end
    chk("r038_cnt_stable", {16'd0, burst_cnt_o}, exp_bursts);
    enable_i = 1'b0;
    step();
    one_shot_i = 1'b0;
    enable_i   = 1'b1;
    wait_valid(50, 6, "r038_restart");

    // Randomized periodic bursts with stalls, loads and preempt positions
    for (int it = 0; it < 8; it++) begin
      p = $urandom_range(6);
      period_i = PW'(p);
      do_burst(60, 30, -1, 0, -1, "rnd", cyc);
      preempt_en_i  = 1'($urandom_range(1));
      preempt_idx_i = IW'($urandom_range(N - 1));
      wait_valid(50, eff_period(p), "rnd");
    end

    // Reset mid-burst at word 2
    ready_i = 1'b1;
    step();
    step();
    ready_i = 1'b0;
    chk("r040_at_idx2", rs1_data_o, model_mem[2]);
    reset_i = 1'b1;
    #1;
    chk("r040_csr", {31'd0, csr_enable_o}, 32'd0);
    chk("r040_level", {30'd0, level_o}, 32'd2);
    chk("r040_cnt", {16'd0, burst_cnt_o}, 32'd0);
    chk("r040_busy", {31'd0, busy_o}, 32'd0);
    chk("r040_data", rs1_data_o, 32'd0);
    step();
    reset_i    = 1'b0;
    exp_bursts = 0;

    // Store contents survive reset
    period_i     = PW'(3);
    preempt_en_i = 1'b0;
    wait_valid(50, 4, "post_rst");
    do_burst(80, 0, -1, 0, -1, "post_rst", cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
